stage_one_arbiter: RTL and testbench

Shares one stage-one preprocessing unit (x/2, x², x→22-bit fixed CORDIC input) between NUM_REQ independent requesters. Round-robin arbitration, single-operation sequencing of the shared unit's start/clk_en/done handshake, result return tagged by one-hot valid, and a watchdog that recovers from a missing done pulse. Sits between the per-channel front ends and the single shared stage-one instance.

---
 rtl/stage_one_arbiter.sv | 148 ++++++++++++++
 tb/tb_stage_one_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_one_arbiter.sv
// Round-robin front end for the single shared stage-one unit (x/2, x^2, x->CORDIC).
// Serialises requesters onto the unit's start/done handshake with a done-watchdog.
module stage_one_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned FLT_DATA_WIDTH = 32,
    parameter int unsigned CORDIC_WIDTH   = 22,
    parameter int unsigned TIMEOUT        = 64,
    parameter int unsigned TIMEOUT_WIDTH  = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req,
    input  logic [NUM_REQ*FLT_DATA_WIDTH-1:0] x_in,
    output logic [NUM_REQ-1:0]                ack,
    output logic [NUM_REQ-1:0]                rsp_valid,
    output logic [FLT_DATA_WIDTH-1:0]         rsp_half,
    output logic [FLT_DATA_WIDTH-1:0]         rsp_square,
    output logic [CORDIC_WIDTH-1:0]           rsp_cordic,
    output logic                              rsp_error,
    output logic                              busy,
    output logic                              s1_start,
    output logic                              s1_clk_en,
    output logic                              s1_rst,
    output logic [FLT_DATA_WIDTH-1:0]         s1_x,
    input  logic [FLT_DATA_WIDTH-1:0]         s1_half,
    input  logic [FLT_DATA_WIDTH-1:0]         s1_square,
    input  logic [CORDIC_WIDTH-1:0]           s1_x_to_cordic,
    input  logic                              s1_done
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                    state;
    logic [IDX_W-1:0]          ptr;
    logic [IDX_W-1:0]          grant;
    logic [TIMEOUT_WIDTH-1:0]  watchdog;

    logic [IDX_W-1:0]          pick_idx;
    logic                      pick_found;
    logic [IDX_W-1:0]          cand_idx;
    int unsigned               cand;
    logic [IDX_W-1:0]          ptr_next;

    logic [FLT_DATA_WIDTH-1:0] x_arr [NUM_REQ];

    for (genvar g = 0; g < int'(NUM_REQ); g++) begin : g_xsplit
        assign x_arr[g] = x_in[g*FLT_DATA_WIDTH +: FLT_DATA_WIDTH];
    end

    // First pending requester at or after ptr, wrapping around.
    always_comb begin
        pick_idx   = ptr;
        pick_found = 1'b0;
        cand       = 0;
        cand_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand     = (32'(ptr) + i) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!pick_found && req[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    assign ptr_next = (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + IDX_W'(1);

    // Sequencer: grant -> start pulse -> wait for done or watchdog -> respond.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            grant      <= '0;
            watchdog   <= '0;
            ack        <= '0;
            rsp_valid  <= '0;
            rsp_half   <= '0;
            rsp_square <= '0;
            rsp_cordic <= '0;
            rsp_error  <= 1'b0;
            busy       <= 1'b0;
            s1_start   <= 1'b0;
            s1_clk_en  <= 1'b0;
            s1_rst     <= 1'b0;
            s1_x       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        s1_x      <= x_arr[pick_idx];
                        grant     <= pick_idx;
                        ack       <= NUM_REQ'(1) << pick_idx;
                        s1_start  <= 1'b1;
                        s1_clk_en <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    ack       <= '0;
                    s1_start  <= 1'b0;
                    s1_clk_en <= 1'b0;
                    watchdog  <= '0;
                    ptr       <= ptr_next;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (s1_done) begin
                        rsp_half   <= s1_half;
                        rsp_square <= s1_square;
                        rsp_cordic <= s1_x_to_cordic;
                        rsp_valid  <= NUM_REQ'(1) << grant;
                        rsp_error  <= 1'b0;
                        state      <= RESP;
                    end else if (watchdog == TIMEOUT_WIDTH'(TIMEOUT - 1)) begin
                        // Unit never answered: return zeros flagged as error and kick its reset.
                        rsp_half   <= '0;
                        rsp_square <= '0;
                        rsp_cordic <= '0;
                        rsp_valid  <= NUM_REQ'(1) << grant;
                        rsp_error  <= 1'b1;
                        s1_rst     <= 1'b1;
                        state      <= RESP;
                    end else begin
                        watchdog <= watchdog + TIMEOUT_WIDTH'(1);
                    end
                end
                RESP: begin
                    // Also gives the shared unit one cooldown cycle before the next start.
                    rsp_valid <= '0;
                    rsp_error <= 1'b0;
                    s1_rst    <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stage_one_arbiter.sv
// Scoreboard bench for stage_one_arbiter: randomized requesters, a fake shared unit,
// a round-robin reference model feeding an expected-response queue.
module tb_stage_one_arbiter;

    localparam int N  = 4;
    localparam int FW = 32;
    localparam int CW = 22;
    localparam int TO = 64;
    localparam int TW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req;
    logic [N*FW-1:0] x_in;
    logic [N-1:0]    ack, rsp_valid;
    logic [FW-1:0]   rsp_half, rsp_square, s1_x, s1_half, s1_square;
    logic [CW-1:0]   rsp_cordic, s1_x_to_cordic;
    logic            rsp_error, busy, s1_start, s1_clk_en, s1_rst, s1_done;
    logic            model_done, stray_done;

    assign s1_done = model_done | stray_done;

    stage_one_arbiter #(
        .NUM_REQ(N), .FLT_DATA_WIDTH(FW), .CORDIC_WIDTH(CW), .TIMEOUT(TO), .TIMEOUT_WIDTH(TW)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .x_in(x_in), .ack(ack), .rsp_valid(rsp_valid),
        .rsp_half(rsp_half), .rsp_square(rsp_square), .rsp_cordic(rsp_cordic),
        .rsp_error(rsp_error), .busy(busy), .s1_start(s1_start), .s1_clk_en(s1_clk_en),
        .s1_rst(s1_rst), .s1_x(s1_x), .s1_half(s1_half), .s1_square(s1_square),
        .s1_x_to_cordic(s1_x_to_cordic), .s1_done(s1_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [31:0] half;
        logic [31:0] sq;
        logic [21:0] cor;
        bit          err;
        int          t_ack;
        int          lat;
    } exp_t;

    exp_t        sbq[$];
    int          grant_log[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;

    // stimulus controls
    int          mode = 0;        // 0 manual, 1 random, 2 all held
    int          rand_ops = 0;
    int          d_sel = 4;       // done latency of next op; 0 = never answers
    bit          dbl = 1'b0;      // done held an extra cycle (stray pulse in RESP)
    logic [N-1:0] pend;
    logic [31:0] pend_x [N];
    logic [N-1:0] ack_prev;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Behaviour of the fake shared unit; the 3.0 case returns the true IEEE results.
    function automatic logic [31:0] m_half(input logic [31:0] x);
        return x - 32'h0080_0000;
    endfunction
    function automatic logic [31:0] m_square(input logic [31:0] x);
        if (x == 32'h4040_0000) return 32'h4110_0000;
        return {x[15:0], x[31:16]} ^ 32'h1357_9BDF;
    endfunction
    function automatic logic [21:0] m_cordic(input logic [31:0] x);
        if (x == 32'h4040_0000) return 22'h06_0000;
        return x[29:8];
    endfunction

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Requesters: hold req/x until ack, change only on the cycle after ack.
    always begin
        @(posedge clk); #2;
        for (int i = 0; i < N; i++) begin
            if (ack_prev[i]) req[i] = 1'b0;
            if (!req[i]) begin
                if (pend[i]) begin
                    req[i] = 1'b1; x_in[i*FW +: FW] = pend_x[i]; pend[i] = 1'b0;
                end else if (mode == 2) begin
                    req[i] = 1'b1; x_in[i*FW +: FW] = $urandom;
                end else if (mode == 1 && rand_ops > 0 && $urandom_range(0, 7) == 0) begin
                    req[i] = 1'b1; x_in[i*FW +: FW] = $urandom; rand_ops--;
                end
            end
        end
        ack_prev = ack;
        if (mode == 1) begin
            d_sel = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 8));
            dbl   = ($urandom_range(0, 3) == 0);
        end
    end

    // Fake shared unit: done rises d cycles after the edge that ends ISSUE.
    int          m_d;
    bit          m_db;
    logic [31:0] m_x;
    always begin
        @(posedge clk); #1;
        if (!rst && s1_start) begin
            m_d = d_sel; m_db = dbl; m_x = s1_x;
            if (m_d > 0) begin
                @(posedge clk);
                repeat (m_d) @(posedge clk);
                #1;
                model_done = 1'b1;
                s1_half = m_half(m_x); s1_square = m_square(m_x); s1_x_to_cordic = m_cordic(m_x);
                @(posedge clk); #1;
                if (m_db) begin @(posedge clk); #1; end
                model_done = 1'b0;
                s1_half = $urandom; s1_square = $urandom; s1_x_to_cordic = 22'($urandom);
            end
        end
    end

    // Control monitor: reference arbitration, pushes expected responses.
    bit busy_prev = 1'b0;
    bit cur_err = 1'b0;
    int exp_rsp_cyc = -100;
    int ref_ptr = 0;
    bit exp_ack, busy_now;
    int w;
    logic [N-1:0] exp_vec;
    exp_t ne;
    always begin
        @(posedge clk); #1;
        if (rst) begin
            sbq.delete(); busy_prev = 1'b0; ref_ptr = 0; exp_rsp_cyc = -100; cur_err = 1'b0;
        end else begin
            exp_ack = !busy_prev && (req != '0);
            exp_vec = '0;
            if (exp_ack) begin
                w = rr_pick(req, ref_ptr);
                exp_vec[w] = 1'b1;
            end
            if (exp_ack || ack != '0) begin
                check("ack", 64'(ack), 64'(exp_vec));
                if (exp_ack) begin
                    ne.idx   = w;
                    ne.err   = (d_sel == 0);
                    ne.half  = ne.err ? 32'h0 : m_half(x_in[w*FW +: FW]);
                    ne.sq    = ne.err ? 32'h0 : m_square(x_in[w*FW +: FW]);
                    ne.cor   = ne.err ? 22'h0 : m_cordic(x_in[w*FW +: FW]);
                    ne.t_ack = cyc;
                    ne.lat   = ne.err ? TO + 1 : d_sel + 2;
                    check("s1_x", 64'(s1_x), 64'(x_in[w*FW +: FW]));
                    sbq.push_back(ne);
                    grant_log.push_back(w);
                    ref_ptr     = (w + 1) % N;
                    exp_rsp_cyc = cyc + ne.lat;
                    cur_err     = ne.err;
                end
            end
            busy_now = exp_ack || (busy_prev && cyc != exp_rsp_cyc + 1);
            check("busy", 64'(busy), 64'(busy_now));
            check("start_clken", 64'({s1_start, s1_clk_en}), 64'({exp_ack, exp_ack}));
            check("s1_rst", 64'(s1_rst), 64'((cyc == exp_rsp_cyc) && cur_err));
            busy_prev = busy_now;
        end
    end

    // Response monitor: pops and compares whenever rsp_valid is presented.
    exp_t pe;
    logic [N-1:0] pv;
    always begin
        @(posedge clk); #1;
        if (!rst && rsp_valid != '0) begin
            if (sbq.size() == 0) begin
                check("rsp_unexpected", 64'(rsp_valid), 64'h0);
            end else begin
                pe = sbq.pop_front();
                pv = '0; pv[pe.idx] = 1'b1;
                check("rsp_valid", 64'(rsp_valid), 64'(pv));
                check("rsp_error", 64'(rsp_error), 64'(pe.err));
                check("rsp_data", {rsp_half, rsp_square}, {pe.half, pe.sq});
                check("rsp_cordic", 64'(rsp_cordic), 64'(pe.cor));
                check("rsp_latency", 64'(cyc - pe.t_ack), 64'(pe.lat));
            end
        end else if (!rst && rsp_error) begin
            check("rsp_error_alone", 64'(rsp_error), 64'h0);
        end
    end

    task automatic wait_quiet(input int budget, input string name);
        int k = 0;
        while (k < budget && !(req == '0 && pend == '0 && rand_ops == 0 && sbq.size() == 0 && !busy)) begin
            @(posedge clk); #3; k++;
        end
        check(name, 64'(k < budget), 64'h1);
    endtask

    task automatic wait_rsp(input int budget, input string name);
        int k = 0;
        do begin @(posedge clk); #1; k++; end while (rsp_valid == '0 && k < budget);
        check(name, 64'(rsp_valid != '0), 64'h1);
    endtask

    task automatic do_reset();
        @(posedge clk); #3 rst = 1'b1;
        @(posedge clk); @(posedge clk); #2 rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rsp"}, {rsp_half, rsp_square}, 64'h0);
        check({tag, "_ctl"}, 64'({ack, rsp_valid, rsp_cordic, rsp_error, busy, s1_start, s1_clk_en, s1_rst}), 64'h0);
        check({tag, "_s1x"}, 64'(s1_x), 64'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        req = '0; x_in = '0; model_done = 1'b0; stray_done = 1'b0; pend = '0; ack_prev = '0;
        s1_half = '0; s1_square = '0; s1_x_to_cordic = '0;
        for (int i = 0; i < N; i++) pend_x[i] = '0;
        #3 check_all_zero("reset");
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // single request, 3.0 with done latency 4
        d_sel = 4; pend_x[0] = 32'h4040_0000; pend[0] = 1'b1;
        wait_rsp(40, "p1_rsp_seen");
        check("p1_half", 64'(rsp_half), 64'h3FC0_0000);
        check("p1_square", 64'(rsp_square), 64'h4110_0000);
        check("p1_cordic", 64'(rsp_cordic), 64'h06_0000);
        check("p1_valid", 64'(rsp_valid), 64'h1);
        wait_quiet(50, "p1_quiet");

        // all four requesters held from reset
        do_reset(); grant_log.delete(); d_sel = 3; mode = 2;
        for (int k = 0; k < 200 && grant_log.size() < 5; k++) begin @(posedge clk); #3; end
        mode = 0;
        wait_quiet(200, "p2_quiet");
        check("p2_count", 64'(grant_log.size() >= 5), 64'h1);
        for (int k = 0; k < 5 && k < grant_log.size(); k++)
            check("p2_order", 64'(grant_log[k]), 64'(k % N));

        // pointer wrap: serve 1 then 3, then 1010 -> 1, then 3
        do_reset(); grant_log.delete();
        pend_x[1] = 32'h3F80_0000; pend[1] = 1'b1; wait_quiet(50, "p3a_quiet");
        pend_x[3] = 32'hC120_0000; pend[3] = 1'b1; wait_quiet(50, "p3b_quiet");
        pend_x[1] = 32'h4100_0000; pend_x[3] = 32'h4200_0000; pend = 4'b1010;
        wait_quiet(100, "p3c_quiet");
        check("p3_count", 64'(grant_log.size()), 64'd4);
        if (grant_log.size() == 4) begin
            check("p3_g2", 64'(grant_log[2]), 64'd1);
            check("p3_g3", 64'(grant_log[3]), 64'd3);
        end

        // watchdog: unit never answers, then a normal op
        d_sel = 0; pend_x[2] = 32'h4080_0000; pend[2] = 1'b1;
        wait_rsp(100, "p4_rsp_seen");
        check("p4_error", 64'({rsp_error, s1_rst}), 64'b11);
        check("p4_data", {rsp_half, rsp_square}, 64'h0);
        @(posedge clk); #1 check("p4_s1rst_clear", 64'(s1_rst), 64'h0);
        wait_quiet(50, "p4a_quiet");
        d_sel = 5; pend_x[2] = 32'h40A0_0000; pend[2] = 1'b1;
        wait_quiet(50, "p4b_quiet");

        // stray done while idle, and a done held into RESP
        @(posedge clk); #3 stray_done = 1'b1;
        @(posedge clk); #3 stray_done = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("p5_idle_busy", 64'({busy, rsp_valid}), 64'h0);
        d_sel = 2; dbl = 1'b1; pend_x[0] = 32'h4140_0000; pend[0] = 1'b1;
        wait_quiet(50, "p5_quiet");
        dbl = 1'b0;

        // randomized traffic with random latencies and occasional timeouts
        rand_ops = 40; mode = 1;
        wait_quiet(8000, "p6_quiet");
        mode = 0; d_sel = 10; dbl = 1'b0;

        // async reset in WAIT; late done must not produce a response
        @(posedge clk); #3;
        pend_x[1] = 32'h4160_0000; pend[1] = 1'b1;
        for (int k = 0; k < 20 && ack == '0; k++) begin @(posedge clk); #1; end
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1 check_all_zero("p7_async");
        @(posedge clk); @(posedge clk); #2 rst = 1'b0;
        repeat (25) @(posedge clk);
        #3 grant_log.delete(); d_sel = 3;
        pend_x[1] = 32'h4180_0000; pend_x[2] = 32'h4190_0000; pend = 4'b0110;
        wait_quiet(100, "p7_quiet");
        check("p7_count", 64'(grant_log.size()), 64'd2);
        if (grant_log.size() == 2) check("p7_first_after_rst", 64'(grant_log[0]), 64'd1);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
